y86_seq_controller: RTL and testbench
=====================================

Name: y86_seq_controller

Overview:
- Stage sequencer for the sequential Y86-64 core.
- Steps fetch, decode, execute, memory, writeback and PC-update through a one-hot stage-enable FSM, one instruction at a time.
- Owns the PC register and processor status (stat), and runs the data-memory request/acknowledge handshake with a timeout.
- Sits beside the fetch/decode/execute/memory datapath. The register file's read and write timing is driven by decode_en and writeback_en.

Parameters:
- RESET_PC, 64'd0: PC loaded on reset and on start.
- CNT_W, 32: width of the cycle and instruction counters.
- MEM_TIMEOUT, 16: cycles dmem_req may wait for dmem_ack before stat becomes ADR.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin execution from RESET_PC; honoured only in IDLE.
- icode  in  4  instruction code from fetch, valid while fetch_en is high.
- instr_valid  in  1  fetch-decoded icode/ifun is legal; sampled with icode.
- imem_error  in  1  instruction fetch address fault; sampled with icode.
- next_pc  in  64  PC-update result from datapath; sampled in PCUPD.
- dmem_req  out  1  data memory request, held until acknowledged.
- dmem_ack  in  1  data memory completion.
- dmem_error  in  1  data address fault; sampled when dmem_ack is high.
- fetch_en, decode_en, execute_en, memory_en, writeback_en  out  1 each  one-hot stage enables.
- pc  out  64  current PC.
- stat  out  2  status: 1=AOK, 2=HLT, 3=ADR, 0=INS.
- busy  out  1  high in any state other than IDLE and HALT.
- cycle_count  out  CNT_W  active cycles since start.
- instr_count  out  CNT_W  instructions retired since start.

Behaviour:
- Reset (asynchronous, immediate):
  - State goes to IDLE; pc=RESET_PC; stat=AOK.
  - All enables, dmem_req and busy are 0; counters are 0; the timeout counter is cleared.
  - A reset mid-instruction abandons it and drops dmem_req in the same instant.
- States: IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, PCUPD, HALT.
- Stage enables: exactly the enable of the current state is high. All enables are 0 in IDLE and HALT. PCUPD has no dedicated enable.
- IDLE: start=1 moves to FETCH, loads pc=RESET_PC, clears both counters and sets stat=AOK.
- FETCH: lasts one cycle, then decides on the sampled inputs in this priority order:
  - imem_error=1: stat=ADR, go to HALT.
  - else instr_valid=0: stat=INS, go to HALT.
  - else icode=0 (halt): stat=HLT, go to HALT.
  - otherwise go to DECODE.
  - In all three fault cases pc is unchanged and instr_count is not incremented.
- DECODE and EXECUTE: one cycle each, in order.
- MEMORY, memory-class icodes (4 rmmovq, 5 mrmovq, 8 call, 9 ret, A pushq, B popq):
  - dmem_req rises on entry and is held until a cycle with dmem_ack=1; it falls the next cycle.
  - If dmem_ack arrives with dmem_error=1: stat=ADR, go to HALT.
  - Otherwise go to WRITEBACK.
  - If MEM_TIMEOUT cycles pass without dmem_ack: drop dmem_req, stat=ADR, go to HALT.
  - dmem_ack in the first request cycle is legal, giving a 1-cycle MEMORY stage.
  - dmem_ack while dmem_req is low is ignored.
- MEMORY, all other icodes: one cycle, dmem_req stays 0.
- WRITEBACK: one cycle, then PCUPD.
- PCUPD: pc<=next_pc, instr_count increments, go to FETCH.
- Cycle totals: a non-memory instruction takes 6 cycles (FETCH to PCUPD). A memory instruction takes 6 + (ack wait cycles).
- cycle_count increments on every cycle where busy=1. Both counters wrap modulo 2^CNT_W.
- HALT: terminal; stat holds; start is ignored; only rst_n leaves HALT.
- start asserted while busy is ignored.

Decomposition:
- Shared package y86_pkg holds:
  - icode constants (IHALT=0 … IPOPQ=B);
  - stat codes SAOK/SHLT/SADR/SINS;
  - controller state encoding.
- One natural sub-module: y86_icode_class, combinational, mapping icode to uses_mem. The memory unit reuses it.
- The FSM, PC register, timeout counter and both counters stay in the top block.

Test Plan:
- Non-memory instruction: reset, start, icode=6 (OPq), instr_valid=1, next_pc=64'd2.
  - Enables pulse F,D,E,M,W across 5 consecutive cycles, then PCUPD.
  - pc=2, instr_count=1, cycle_count=6.
  - dmem_req is never high.
- Memory instruction with wait: icode=4 (rmmovq), dmem_ack after 3 request cycles, next_pc=10.
  - dmem_req high for exactly 3 cycles.
  - pc=10, stat=AOK, cycle_count=8.
- Halt: icode=0 on the second fetch.
  - stat=HLT, halted in HALT, pc holds the first next_pc, instr_count=1, busy=0.
  - A subsequent start pulse has no effect.
- Fetch fault priority: imem_error=1 with instr_valid=0 → stat=ADR, not INS.
  - Separately, instr_valid=0 alone → stat=INS.
- Memory timeout and error:
  - icode=5 with dmem_ack never asserted → dmem_req drops after 16 cycles, stat=ADR.
  - Separately, dmem_ack=1 with dmem_error=1 → stat=ADR.
- Reset mid-MEMORY: rst_n low while dmem_req=1 → dmem_req=0 immediately, with no clock edge.
  - pc=0, stat=AOK, counters 0, state IDLE after release.

Source files
------------

// File: rtl/y86_seq_controller_pkg.sv
// ============================================================================
//  Module      : y86_pkg
//  Description : Shared definitions for the sequential Y86-64 core:
//                instruction codes, processor status codes and the
//                controller state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package y86_pkg;

    // Instruction codes (icode field of the first instruction byte)
    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    // Processor status codes
    localparam logic [1:0] SINS = 2'd0;
    localparam logic [1:0] SAOK = 2'd1;
    localparam logic [1:0] SHLT = 2'd2;
    localparam logic [1:0] SADR = 2'd3;

    // Controller states
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_MEMORY    = 3'd4,
        ST_WRITEBACK = 3'd5,
        ST_PCUPD     = 3'd6,
        ST_HALT      = 3'd7
    } ctrl_state_t;

    // True for instructions that access data memory in the MEMORY stage
    function automatic logic icode_uses_mem(input logic [3:0] icode);
        logic uses;
        uses = 1'b0;
        case (icode)
            IRMMOVQ, IMRMOVQ, ICALL, IRET, IPUSHQ, IPOPQ: uses = 1'b1;
            default:                                      uses = 1'b0;
        endcase
        return uses;
    endfunction

endpackage

`default_nettype wire

// File: rtl/y86_seq_controller_icode_class.sv
// ============================================================================
//  Module      : y86_icode_class
//  Description : Combinational instruction classifier. Flags icodes that
//                perform a data-memory access; shared with the memory unit.
//  Ports       : icode    (in,  4) instruction code
//                uses_mem (out, 1) instruction accesses data memory
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module y86_icode_class
    import y86_pkg::*;
(
    input  logic [3:0] icode,
    output logic       uses_mem
);

    always_comb begin
        uses_mem = icode_uses_mem(icode);
    end

endmodule

`default_nettype wire

// File: rtl/y86_seq_controller.sv
// ============================================================================
//  Module      : y86_seq_controller
//  Description : Stage sequencer for the sequential Y86-64 core. Walks one
//                instruction at a time through FETCH, DECODE, EXECUTE,
//                MEMORY, WRITEBACK and PC-update, owns the PC and the
//                processor status, and runs the data-memory handshake with
//                a timeout.
//  Ports       : clk, rst_n               clock, async active-low reset
//                start                    begin execution (IDLE only)
//                icode/instr_valid/
//                imem_error               fetch results, sampled in FETCH
//                next_pc                  PC-update result, sampled in PCUPD
//                dmem_req/dmem_ack/
//                dmem_error               data-memory handshake
//                fetch_en..writeback_en   one-hot stage enables
//                pc, stat, busy           architectural PC, status, activity
//                cycle_count/instr_count  performance counters
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module y86_seq_controller
    import y86_pkg::*;
#(
    parameter logic [63:0] RESET_PC    = 64'd0,
    parameter int          CNT_W       = 32,
    parameter int          MEM_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       icode,
    input  logic             instr_valid,
    input  logic             imem_error,
    input  logic [63:0]      next_pc,
    output logic             dmem_req,
    input  logic             dmem_ack,
    input  logic             dmem_error,
    output logic             fetch_en,
    output logic             decode_en,
    output logic             execute_en,
    output logic             memory_en,
    output logic             writeback_en,
    output logic [63:0]      pc,
    output logic [1:0]       stat,
    output logic             busy,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instr_count
);

    // The timeout counter only has to reach MEM_TIMEOUT-1: the cycle that
    // holds that value is the last request cycle allowed.
    localparam int TO_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [TO_W-1:0] C_TIMEOUT_LAST = TO_W'(MEM_TIMEOUT - 1);

    ctrl_state_t       r_state;
    ctrl_state_t       w_next_state;
    logic [63:0]       r_pc;
    logic [1:0]        r_stat;
    logic [1:0]        w_next_stat;
    logic [3:0]        r_icode;
    logic [TO_W-1:0]   r_timeout;
    logic [CNT_W-1:0]  r_cycle_count;
    logic [CNT_W-1:0]  r_instr_count;
    logic              w_uses_mem;
    logic              w_start_run;
    logic              w_retire;
    logic              w_busy;

    // Classification uses the icode captured at the end of FETCH so the
    // fetch inputs are free to change once FETCH is over.
    y86_icode_class u_icode_class (
        .icode    (r_icode),
        .uses_mem (w_uses_mem)
    );

    assign w_busy = (r_state != ST_IDLE) && (r_state != ST_HALT);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_next_stat  = r_stat;
        w_start_run  = 1'b0;
        w_retire     = 1'b0;
        fetch_en     = 1'b0;
        decode_en    = 1'b0;
        execute_en   = 1'b0;
        memory_en    = 1'b0;
        writeback_en = 1'b0;
        dmem_req     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_start_run  = 1'b1;
                    w_next_stat  = SAOK;
                    w_next_state = ST_FETCH;
                end
            end

            ST_FETCH: begin
                fetch_en = 1'b1;
                // Address fault outranks illegal instruction, which
                // outranks a legal halt.
                if (imem_error) begin
                    w_next_stat  = SADR;
                    w_next_state = ST_HALT;
                end else if (!instr_valid) begin
                    w_next_stat  = SINS;
                    w_next_state = ST_HALT;
                end else if (icode == IHALT) begin
                    w_next_stat  = SHLT;
                    w_next_state = ST_HALT;
                end else begin
                    w_next_state = ST_DECODE;
                end
            end

            ST_DECODE: begin
                decode_en    = 1'b1;
                w_next_state = ST_EXECUTE;
            end

            ST_EXECUTE: begin
                execute_en   = 1'b1;
                w_next_state = ST_MEMORY;
            end

            ST_MEMORY: begin
                memory_en = 1'b1;
                if (w_uses_mem) begin
                    // Request is a pure function of the state, so it falls
                    // the cycle after the ack and drops instantly on reset.
                    dmem_req = 1'b1;
                    if (dmem_ack) begin
                        if (dmem_error) begin
                            w_next_stat  = SADR;
                            w_next_state = ST_HALT;
                        end else begin
                            w_next_state = ST_WRITEBACK;
                        end
                    end else if (r_timeout == C_TIMEOUT_LAST) begin
                        w_next_stat  = SADR;
                        w_next_state = ST_HALT;
                    end
                end else begin
                    w_next_state = ST_WRITEBACK;
                end
            end

            ST_WRITEBACK: begin
                writeback_en = 1'b1;
                w_next_state = ST_PCUPD;
            end

            ST_PCUPD: begin
                w_retire     = 1'b1;
                w_next_state = ST_FETCH;
            end

            ST_HALT: begin
                w_next_state = ST_HALT;
            end

            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // PC, status, timeout and counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc          <= RESET_PC;
            r_stat        <= SAOK;
            r_icode       <= IHALT;
            r_timeout     <= '0;
            r_cycle_count <= '0;
            r_instr_count <= '0;
        end else begin
            r_stat <= w_next_stat;

            if (r_state == ST_FETCH) begin
                r_icode <= icode;
            end

            // Counts request cycles spent waiting in MEMORY; restarts on
            // every entry since it is cleared whenever MEMORY is left.
            if ((w_next_state == ST_MEMORY) && dmem_req) begin
                r_timeout <= r_timeout + 1'b1;
            end else begin
                r_timeout <= '0;
            end

            if (w_start_run) begin
                r_pc <= RESET_PC;
            end else if (w_retire) begin
                r_pc <= next_pc;
            end

            if (w_start_run) begin
                r_cycle_count <= '0;
            end else if (w_busy) begin
                r_cycle_count <= r_cycle_count + 1'b1;
            end

            if (w_start_run) begin
                r_instr_count <= '0;
            end else if (w_retire) begin
                r_instr_count <= r_instr_count + 1'b1;
            end
        end
    end

    assign pc          = r_pc;
    assign stat        = r_stat;
    assign busy        = w_busy;
    assign cycle_count = r_cycle_count;
    assign instr_count = r_instr_count;

endmodule

`default_nettype wire

// File: tb/tb_y86_seq_controller.sv
// ============================================================================
//  Module      : tb_y86_seq_controller
//  Description : Scoreboard bench for y86_seq_controller. The stimulus side
//                issues one instruction per FETCH and queues the expected
//                architectural result; a monitor pops and compares at each
//                retirement or halt.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_y86_seq_controller;

    localparam logic [63:0] RESET_PC = 64'd0;
    localparam int          TMO      = 16;

    localparam logic [1:0] S_INS = 2'd0;
    localparam logic [1:0] S_AOK = 2'd1;
    localparam logic [1:0] S_HLT = 2'd2;
    localparam logic [1:0] S_ADR = 2'd3;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [3:0]  icode;
    logic        instr_valid;
    logic        imem_error;
    logic [63:0] next_pc;
    logic        dmem_req;
    logic        dmem_ack;
    logic        dmem_error;
    logic        fetch_en, decode_en, execute_en, memory_en, writeback_en;
    logic [63:0] pc;
    logic [1:0]  stat;
    logic        busy;
    logic [31:0] cycle_count;
    logic [31:0] instr_count;

    y86_seq_controller #(
        .RESET_PC    (RESET_PC),
        .CNT_W       (32),
        .MEM_TIMEOUT (TMO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .icode        (icode),
        .instr_valid  (instr_valid),
        .imem_error   (imem_error),
        .next_pc      (next_pc),
        .dmem_req     (dmem_req),
        .dmem_ack     (dmem_ack),
        .dmem_error   (dmem_error),
        .fetch_en     (fetch_en),
        .decode_en    (decode_en),
        .execute_en   (execute_en),
        .memory_en    (memory_en),
        .writeback_en (writeback_en),
        .pc           (pc),
        .stat         (stat),
        .busy         (busy),
        .cycle_count  (cycle_count),
        .instr_count  (instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [63:0] pc;
        logic [1:0]  stat;
        int          icnt;
        int          ccnt;
        string       seq;
        int          req;
    } exp_t;

    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    // Reference model of the architectural state
    logic [63:0] md_pc;
    int          md_icnt;
    int          md_ccnt;

    // Memory responder configuration: ack on the Nth request cycle (0 = never)
    int   resp_delay = 0;
    logic resp_err   = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_s(input string nm, input string act, input string exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got \"%s\" expected \"%s\"", nm, act, exp);
        end
    endtask

    function automatic bit is_mem(input logic [3:0] ic);
        return (ic == 4'h4) || (ic == 4'h5) || (ic == 4'h8) ||
               (ic == 4'h9) || (ic == 4'hA) || (ic == 4'hB);
    endfunction

    // ------------------------------------------------------------------
    // Memory responder
    // ------------------------------------------------------------------
    initial begin
        int cnt;
        cnt        = 0;
        dmem_ack   = 1'b0;
        dmem_error = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && dmem_req) begin
                cnt++;
                if (resp_delay > 0 && cnt == resp_delay) begin
                    dmem_ack   = 1'b1;
                    dmem_error = resp_err;
                end else begin
                    dmem_ack   = 1'b0;
                    dmem_error = 1'b0;
                end
            end else begin
                cnt        = 0;
                dmem_ack   = 1'b0;
                dmem_error = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    string m_seq;
    int    m_req;
    logic  m_prev_busy;
    logic  m_prev_pcupd;

    task automatic compare_event();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got event with pc=%0h stat=%0d, expected none", pc, stat);
        end else begin
            e = sb.pop_front();
            chk({e.name, ".pc"}, pc, e.pc);
            chk({e.name, ".stat"}, 64'(stat), 64'(e.stat));
            chk({e.name, ".instr_count"}, 64'(instr_count), 64'(e.icnt));
            chk({e.name, ".cycle_count"}, 64'(cycle_count), 64'(e.ccnt));
            chk({e.name, ".req_cycles"}, 64'(m_req), 64'(e.req));
            chk_s({e.name, ".stages"}, m_seq, e.seq);
        end
    endtask

    initial begin
        logic [4:0] en;
        m_seq        = "";
        m_req        = 0;
        m_prev_busy  = 1'b0;
        m_prev_pcupd = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_seq        = "";
                m_req        = 0;
                m_prev_busy  = 1'b0;
                m_prev_pcupd = 1'b0;
            end else begin
                en = {fetch_en, decode_en, execute_en, memory_en, writeback_en};
                if (m_prev_pcupd || (m_prev_busy && !busy)) begin
                    compare_event();
                    m_seq = "";
                    m_req = 0;
                end
                checks++;
                if ($countones(en) > 1 || (!busy && en != 5'b0)) begin
                    errors++;
                    $display("FAIL enable_onehot: got en=%b busy=%b, expected at most one enable and none when idle", en, busy);
                end
                if (fetch_en)     m_seq = {m_seq, "F"};
                if (decode_en)    m_seq = {m_seq, "D"};
                if (execute_en)   m_seq = {m_seq, "E"};
                if (memory_en)    m_seq = {m_seq, "M"};
                if (writeback_en) m_seq = {m_seq, "W"};
                if (busy && en == 5'b0) m_seq = {m_seq, "P"};
                if (dmem_req) m_req++;
                m_prev_busy  = busy;
                m_prev_pcupd = busy && (en == 5'b0);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic reset_dut();
        rst_n       = 1'b0;
        start       = 1'b0;
        icode       = 4'h1;
        instr_valid = 1'b1;
        imem_error  = 1'b0;
        next_pc     = 64'd0;
        resp_delay  = 0;
        resp_err    = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        md_pc   = RESET_PC;
        md_icnt = 0;
        md_ccnt = 0;
    endtask

    task automatic issue(input string nm, input logic [3:0] ic, input logic vld,
                         input logic ierr, input logic [63:0] npc, input int dly,
                         input logic derr, input bit push);
        exp_t e;
        int   guard;
        int   k;
        guard = 0;
        while (!fetch_en && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!fetch_en) begin
            checks++;
            errors++;
            $display("FAIL %s.fetch_timeout: got no fetch_en, expected fetch within 200 cycles", nm);
            return;
        end
        icode       = ic;
        instr_valid = vld;
        imem_error  = ierr;
        next_pc     = npc;
        resp_delay  = dly;
        resp_err    = derr;

        e.name = nm;
        e.req  = 0;
        if (ierr || !vld || ic == 4'h0) begin
            e.stat   = ierr ? S_ADR : (!vld ? S_INS : S_HLT);
            e.seq    = "F";
            md_ccnt += 1;
        end else begin
            k = 1;
            if (is_mem(ic)) begin
                k     = (dly == 0) ? TMO : dly;
                e.req = k;
            end
            e.seq = "FDE";
            for (int i = 0; i < k; i++) e.seq = {e.seq, "M"};
            if (is_mem(ic) && (dly == 0 || derr)) begin
                e.stat   = S_ADR;
                md_ccnt += 3 + k;
            end else begin
                e.stat   = S_AOK;
                e.seq    = {e.seq, "WP"};
                md_ccnt += 5 + k;
                md_icnt += 1;
                md_pc    = npc;
            end
        end
        e.pc   = md_pc;
        e.icnt = md_icnt;
        e.ccnt = md_ccnt;
        if (push) sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic drain(input string nm);
        int guard;
        guard = 0;
        while (sb.size() != 0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s.drain: got %0d pending, expected 0", nm, sb.size());
            sb.delete();
        end
    endtask

    // ------------------------------------------------------------------
    // Directed scenarios
    // ------------------------------------------------------------------
    initial begin
        int guard;
        rst_n = 1'b0;
        reset_dut();

        // Reset state
        chk("rst.pc", pc, RESET_PC);
        chk("rst.stat", 64'(stat), 64'(S_AOK));
        chk("rst.busy", 64'(busy), 64'd0);
        chk("rst.cycle_count", 64'(cycle_count), 64'd0);
        chk("rst.instr_count", 64'(instr_count), 64'd0);
        chk("rst.dmem_req", 64'(dmem_req), 64'd0);

        // Program: OPq, rmmovq (3-cycle wait), call (1-cycle ack), rrmovq, halt
        do_start();
        issue("opq",    4'h6, 1'b1, 1'b0, 64'd2,     0, 1'b0, 1'b1);
        issue("rmmovq", 4'h4, 1'b1, 1'b0, 64'd10,    3, 1'b0, 1'b1);
        issue("call",   4'h8, 1'b1, 1'b0, 64'h40,    1, 1'b0, 1'b1);
        issue("rrmovq", 4'h2, 1'b1, 1'b0, 64'h42,    0, 1'b0, 1'b1);
        issue("halt",   4'h0, 1'b1, 1'b0, 64'hdead,  0, 1'b0, 1'b1);
        drain("prog");
        chk("halt.busy", 64'(busy), 64'd0);

        // start is ignored once halted
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("halt_start.busy", 64'(busy), 64'd0);
        chk("halt_start.stat", 64'(stat), 64'(S_HLT));
        chk("halt_start.pc", pc, 64'h42);
        chk("halt_start.fetch_en", 64'(fetch_en), 64'd0);

        // imem_error outranks an invalid instruction
        reset_dut();
        do_start();
        issue("imem_err", 4'h6, 1'b0, 1'b1, 64'd8, 0, 1'b0, 1'b1);
        drain("imem_err");

        // Invalid instruction alone
        reset_dut();
        do_start();
        issue("ins", 4'hC, 1'b0, 1'b0, 64'd8, 0, 1'b0, 1'b1);
        drain("ins");

        // Data-memory timeout after an earlier retirement
        reset_dut();
        do_start();
        issue("nop",     4'h1, 1'b1, 1'b0, 64'd1, 0, 1'b0, 1'b1);
        issue("timeout", 4'h5, 1'b1, 1'b0, 64'd9, 0, 1'b0, 1'b1);
        drain("timeout");

        // Data-memory error on a 1-cycle ack
        reset_dut();
        do_start();
        issue("dmem_err", 4'hB, 1'b1, 1'b0, 64'd2, 1, 1'b1, 1'b1);
        drain("dmem_err");

        // Asynchronous reset in the middle of a memory request
        reset_dut();
        do_start();
        issue("pre_rst", 4'h6, 1'b1, 1'b0, 64'd2,    0, 1'b0, 1'b1);
        issue("mid_rst", 4'h5, 1'b1, 1'b0, 64'h99,   0, 1'b0, 1'b0);
        guard = 0;
        while (!dmem_req && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk("mid_rst.req_seen", 64'(dmem_req), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst.dmem_req", 64'(dmem_req), 64'd0);
        chk("mid_rst.busy", 64'(busy), 64'd0);
        chk("mid_rst.memory_en", 64'(memory_en), 64'd0);
        chk("mid_rst.pc", pc, RESET_PC);
        chk("mid_rst.stat", 64'(stat), 64'(S_AOK));
        chk("mid_rst.cycle_count", 64'(cycle_count), 64'd0);
        chk("mid_rst.instr_count", 64'(instr_count), 64'd0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_rst.busy", 64'(busy), 64'd0);
        chk("post_rst.fetch_en", 64'(fetch_en), 64'd0);
        chk("post_rst.pc", pc, RESET_PC);
        drain("mid_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
